// File: rtl/pwm_fade_sequencer.sv
// Purpose: steps each PWM channel's duty value 1 LSB per scan toward its programmed target, paced by ramp_wrap.
// Latency: a step event starts a scan next cycle; channel n updates n+1 cycles after the event edge; INSTANT writes update next cycle.
// Backpressure: none; a step arriving mid-scan is held in one pending flag, and further steps are dropped until that flag is consumed.
module pwm_fade_sequencer #(
    parameter int NCH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ramp_wrap,
    input  logic             wen,
    input  logic [3:0]       waddr,
    input  logic [7:0]       wdata,
    input  logic [3:0]       raddr,
    output logic [7:0]       rdata,
    output logic [NCH*8-1:0] pwm_val,
    output logic             busy,
    output logic             done
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    cur_q [NCH];
    logic [7:0]    cur_d [NCH];
    logic [7:0]    tgt_q [NCH];
    logic [7:0]    tgt_d [NCH];
    logic [7:0]    rate_q, rate_d;
    logic [7:0]    presc_q, presc_d;
    logic          en_q, en_d;
    logic          inst_q, inst_d;
    logic          pend_q, pend_d;
    logic          busy_q, busy_d;
    logic          done_q;
    logic          step;
    logic          wr_tgt;
    logic [IW-1:0] widx;
    logic [7:0]    vis_cur, vis_tgt;

    // Addresses below NCH map onto TARGET registers; with NCH < 8 the unused slots read 0.
    assign wr_tgt = wen && ({1'b0, waddr} < 5'(NCH));
    assign widx   = IW'(waddr);

    // Channel n's duty value comes straight from its current-value register.
    for (genvar g = 0; g < NCH; g++) begin : g_pwm
        assign pwm_val[8*g +: 8] = cur_q[g];
    end

    assign busy = busy_q;
    assign done = done_q;

    // Next-state logic: prescaler, scan FSM, per-channel stepping, register writes, busy.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        presc_d = presc_q;
        rate_d  = rate_q;
        en_d    = en_q;
        inst_d  = inst_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        step    = 1'b0;
        vis_cur = cur_q[idx_q];
        vis_tgt = tgt_q[idx_q];
        busy_d  = 1'b0;

        if (ramp_wrap && en_q) begin
            if (presc_q == rate_q) begin
                step    = 1'b1;
                presc_d = 8'd0;
            end else begin
                presc_d = presc_q + 8'd1;
            end
        end
        if (wen && waddr == 4'd8) begin
            presc_d = 8'd0;
        end

        case (state_q)
            IDLE: begin
                if (step || pend_q) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            SCAN: begin
                if (step) begin
                    pend_d = 1'b1;
                end
                // Frozen while disabled, even if a pending step started this scan.
                if (en_q) begin
                    if (vis_cur < vis_tgt) begin
                        cur_d[idx_q] = vis_cur + 8'd1;
                    end else if (vis_cur > vis_tgt) begin
                        cur_d[idx_q] = vis_cur - 8'd1;
                    end
                end
                if (idx_q == IW'(NCH - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Writes land after the scan update so an INSTANT load wins over the step.
        if (wr_tgt) begin
            tgt_d[widx] = wdata;
            if (inst_q) begin
                cur_d[widx] = wdata;
            end
        end
        if (wen && waddr == 4'd8) begin
            rate_d = wdata;
        end
        if (wen && waddr == 4'd9) begin
            en_d   = wdata[0];
            inst_d = wdata[1];
        end

        for (int i = 0; i < NCH; i++) begin
            if (cur_d[i] != tgt_d[i]) begin
                busy_d = 1'b1;
            end
        end
    end

    // State registers; busy tracks the values the same edge commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            presc_q <= 8'd0;
            rate_q  <= 8'd0;
            en_q    <= 1'b1;
            inst_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cur_q[i] <= 8'd0;
                tgt_q[i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            presc_q <= presc_d;
            rate_q  <= rate_d;
            en_q    <= en_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= busy_q & ~busy_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
        end
    end

    // Register read mux; TARGET reads return the target, not the current value.
    always_comb begin
        rdata = 8'd0;
        if ({1'b0, raddr} < 5'(NCH)) begin
            rdata = tgt_q[IW'(raddr)];
        end else begin
            case (raddr)
                4'd8:    rdata = rate_q;
                4'd9:    rdata = {6'd0, inst_q, en_q};
                4'd10:   rdata = {7'd0, busy_q};
                default: rdata = 8'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Purpose: directed stimulus for pwm_fade_sequencer with a queued-expectation scoreboard.
// Latency: expectations are drained by the monitor on the falling edge after they are queued.
// Backpressure: none; stimulus waits for each drain before moving on.
module tb_pwm_fade_sequencer;
    localparam int NCH = 8;

    localparam int K_CH    = 0;
    localparam int K_ALL   = 1;
    localparam int K_BUSY  = 2;
    localparam int K_DONES = 3;
    localparam int K_RD    = 4;
    localparam int K_DONE  = 5;

    typedef struct {
        string       name;
        int          kind;
        int          arg;
        logic [63:0] exp;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ramp_wrap;
    logic             wen;
    logic [3:0]       waddr;
    logic [7:0]       wdata;
    logic [3:0]       raddr;
    logic [7:0]       rdata;
    logic [NCH*8-1:0] pwm_val;
    logic             busy;
    logic             done;

    exp_t        q[$];
    exp_t        cur_e;
    logic [63:0] act;
    logic        smp = 1'b0;
    int          done_seen = 0;
    int          checks = 0;
    int          failures = 0;
    int          exp28 [6] = '{0, 0, 1, 1, 1, 2};

    pwm_fade_sequencer #(.NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ramp_wrap (ramp_wrap),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .pwm_val   (pwm_val),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Monitor: counts done pulses and drains queued expectations when a sample is requested.
    always @(negedge clk) begin
        if (done) done_seen = done_seen + 1;
        if (smp) begin
            while (q.size() > 0) begin
                cur_e = q.pop_front();
                case (cur_e.kind)
                    K_CH:    act = 64'(pwm_val[8*cur_e.arg +: 8]);
                    K_ALL:   act = 64'(pwm_val);
                    K_BUSY:  act = 64'(busy);
                    K_DONE:  act = 64'(done);
                    K_RD:    act = 64'(rdata);
                    default: begin
                        act       = 64'(done_seen);
                        done_seen = 0;
                    end
                endcase
                checks = checks + 1;
                if (act !== cur_e.exp) begin
                    failures = failures + 1;
                    $display("FAIL %s: got %0h expected %0h", cur_e.name, act, cur_e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        wen   = 1'b0;
    endtask

    task automatic pulse();
        ramp_wrap = 1'b1;
        tick();
        ramp_wrap = 1'b0;
    endtask

    task automatic chk(input string n, input int k, input int a, input logic [63:0] e);
        exp_t x;
        x.name = n;
        x.kind = k;
        x.arg  = a;
        x.exp  = e;
        if (k == K_RD) raddr = 4'(a);
        q.push_back(x);
        smp = 1'b1;
        @(negedge clk);
        #1;
        smp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ramp_wrap = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        repeat (3) tick();
        chk("reset_pwm_all", K_ALL, 0, 64'h0);
        chk("reset_busy", K_BUSY, 0, 64'h0);
        chk("reset_done", K_DONE, 0, 64'h0);
        rst_n = 1'b1;
        tick();
        chk("reset_ctrl", K_RD, 9, 64'h01);
        chk("reset_rate", K_RD, 8, 64'h00);
        chk("reset_status", K_RD, 10, 64'h00);
        chk("reset_no_dones", K_DONES, 0, 64'h0);

        // Basic fade of channel 3 to 4 with RATE=0.
        wr(4'd3, 8'h04);
        chk("fade_busy_rise", K_BUSY, 0, 64'h1);
        chk("fade_rd_target", K_RD, 3, 64'h04);
        for (int k = 1; k <= 4; k++) begin
            pulse();
            repeat (NCH - 1) tick();
            chk("fade_ch3_step", K_CH, 3, 64'(k));
            tick();
            tick();
        end
        chk("fade_busy_fall", K_BUSY, 0, 64'h0);
        chk("fade_one_done", K_DONES, 0, 64'h1);
        chk("fade_others_zero", K_ALL, 0, 64'h0000_0000_0400_0000);

        // RATE=2: steps on the 3rd and 6th pulse only.
        wr(4'd8, 8'd2);
        wr(4'd5, 8'h10);
        for (int i = 0; i < 6; i++) begin
            pulse();
            repeat (NCH + 1) tick();
            chk("rate2_ch5", K_CH, 5, 64'(exp28[i]));
        end
        wr(4'd5, 8'h02);
        chk("rate2_busy_fall", K_BUSY, 0, 64'h0);
        chk("rate2_done", K_DONES, 0, 64'h1);
        wr(4'd8, 8'd0);

        // INSTANT load.
        wr(4'd9, 8'h03);
        wr(4'd0, 8'hC8);
        chk("instant_ch0", K_CH, 0, 64'hC8);
        chk("instant_busy", K_BUSY, 0, 64'h0);
        chk("instant_rd_tgt", K_RD, 0, 64'hC8);
        chk("instant_rd_ctrl", K_RD, 9, 64'h03);
        chk("instant_no_done", K_DONES, 0, 64'h0);

        // Saturation at 0xFF/0x00, then freeze with EN=0.
        wr(4'd2, 8'hFF);
        wr(4'd9, 8'h01);
        for (int i = 0; i < 10; i++) begin
            pulse();
            repeat (NCH + 1) tick();
        end
        chk("sat_ch2_ff", K_CH, 2, 64'hFF);
        chk("sat_ch0_c8", K_CH, 0, 64'hC8);
        chk("sat_ch7_00", K_CH, 7, 64'h00);
        chk("sat_busy", K_BUSY, 0, 64'h0);
        chk("sat_no_done", K_DONES, 0, 64'h0);
        wr(4'd9, 8'h00);
        wr(4'd1, 8'h10);
        chk("freeze_busy_rise", K_BUSY, 0, 64'h1);
        for (int i = 0; i < 3; i++) begin
            pulse();
            repeat (NCH + 1) tick();
        end
        chk("freeze_ch1", K_CH, 1, 64'h00);
        chk("freeze_busy", K_BUSY, 0, 64'h1);
        chk("freeze_rd_ctrl", K_RD, 9, 64'h00);
        chk("freeze_rd_tgt1", K_RD, 1, 64'h10);
        wr(4'd9, 8'h03);
        wr(4'd1, 8'h00);
        chk("cleanup_busy", K_BUSY, 0, 64'h0);
        chk("cleanup_done", K_DONES, 0, 64'h1);
        wr(4'd9, 8'h01);

        // Back-to-back pulses during a scan: one pending scan, third pulse dropped.
        wr(4'd4, 8'h10);
        pulse();
        tick();
        pulse();
        tick();
        pulse();
        repeat (30) tick();
        chk("pending_ch4", K_CH, 4, 64'h02);
        chk("pending_busy", K_BUSY, 0, 64'h1);

        // Reset during the 4th cycle of a scan.
        pulse();
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("midreset_pwm", K_ALL, 0, 64'h0);
        chk("midreset_busy", K_BUSY, 0, 64'h0);
        chk("midreset_done", K_DONE, 0, 64'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("postreset_ctrl", K_RD, 9, 64'h01);
        chk("postreset_tgt4", K_RD, 4, 64'h00);
        wr(4'd4, 8'h05);
        repeat (20) tick();
        chk("postreset_no_step", K_CH, 4, 64'h00);
        chk("postreset_busy", K_BUSY, 0, 64'h1);
        pulse();
        repeat (NCH + 1) tick();
        chk("postreset_step", K_CH, 4, 64'h01);

        tick();
        if (q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
